// File: rtl/tqv_bus_pkg.sv
// Shared definitions for the TinyQV peripheral bus.
//   size_e       : transfer size encoding, also the active-low strobe value
//                  driven onto data_write_n / data_read_n
//   rsp_err_e    : response status returned to the upstream requester
//   mask_by_size : zero-extends read data to the transfer size
package tqv_bus_pkg;

    typedef enum logic [1:0] {
        SZ_8    = 2'b00,
        SZ_16   = 2'b01,
        SZ_32   = 2'b10,
        SZ_NONE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_SIZE    = 2'b10
    } rsp_err_e;

    function automatic logic [31:0] mask_by_size(input logic [31:0] data,
                                                 input size_e       size);
        logic [31:0] res;
        res = '0;
        case (size)
            SZ_8:    res = {24'h000000, data[7:0]};
            SZ_16:   res = {16'h0000, data[15:0]};
            SZ_32:   res = data;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tqv_periph_initiator.sv
// Bus initiator for the TinyQV peripheral interface. Accepts one request at a
// time over a valid/ready handshake, issues a single write strobe or a held
// read strobe to the peripheral, and returns read data or an error code over
// a valid/ready response handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write/size/addr/wdata request fields
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        response fields (stable while rsp_valid)
//   address/data_in          registered peripheral address and write data
//   data_write_n/data_read_n registered peripheral strobes (11 = idle)
//   data_out/data_ready      peripheral read data and its valid flag
module tqv_periph_initiator
    import tqv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t WRITE = 2'd1;
    localparam state_t READ  = 2'd2;
    localparam state_t RESP  = 2'd3;

    state_t           state_q,     state_d;
    logic [5:0]       address_q,   address_d;
    logic [31:0]      data_in_q,   data_in_d;
    logic [1:0]       wr_n_q,      wr_n_d;
    logic [1:0]       rd_n_q,      rd_n_d;
    logic [1:0]       size_q,      size_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    rsp_err_e         rsp_err_q,   rsp_err_d;

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        data_in_d   = data_in_q;
        wr_n_d      = wr_n_q;
        rd_n_d      = rd_n_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d      = req_size;
                    rsp_rdata_d = '0;
                    rsp_err_d   = ERR_OK;
                    if (req_size == SZ_NONE) begin
                        // Illegal size: answer directly, peripheral untouched.
                        rsp_err_d = ERR_SIZE;
                        state_d   = RESP;
                    end else if (req_write) begin
                        address_d = req_addr;
                        data_in_d = req_wdata;
                        wr_n_d    = req_size;
                        state_d   = WRITE;
                    end else begin
                        address_d = req_addr;
                        rd_n_d    = req_size;
                        cnt_d     = '0;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                wr_n_d  = 2'b11;
                state_d = RESP;
            end
            READ: begin
                // data_ready takes priority over an expiring timeout.
                if (data_ready) begin
                    rsp_rdata_d = mask_by_size(data_out, size_e'(size_q));
                    rd_n_d      = 2'b11;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = ERR_TIMEOUT;
                    rd_n_d      = 2'b11;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            address_q   <= '0;
            data_in_q   <= '0;
            wr_n_q      <= '1;
            rd_n_q      <= '1;
            size_q      <= '0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = wr_n_q;
    assign data_read_n  = rd_n_q;

endmodule

// File: tb/tb_tqv_periph_initiator.sv
// Directed testbench for tqv_periph_initiator: writes, masked reads, read
// timeout, illegal size with response back-pressure, and reset mid-read.
module tb_tqv_periph_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int unsigned checks;
    int unsigned failures;

    tqv_periph_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a request for one cycle; returns just after the accepting edge.
    task automatic send_req(input logic wr, input logic [1:0] sz,
                            input logic [5:0] ad, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = ad;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        data_out   = '0;
        data_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err",   32'(rsp_err), 32'd0);
        check_eq("rst_wr_n",      32'(data_write_n), 32'd3);
        check_eq("rst_rd_n",      32'(data_read_n), 32'd3);
        check_eq("rst_address",   32'(address), 32'd0);
        check_eq("rst_data_in",   data_in, 32'h0);
        rst = 1'b0;
        tick();

        // 1: 32-bit write
        send_req(1'b1, 2'b10, 6'd3, 32'h0000ABCD);
        check_eq("w_strobe",     32'(data_write_n), 32'd2);
        check_eq("w_data_in",    data_in, 32'h0000ABCD);
        check_eq("w_address",    32'(address), 32'd3);
        check_eq("w_rd_idle",    32'(data_read_n), 32'd3);
        check_eq("w_rsp_early",  32'(rsp_valid), 32'd0);
        tick();
        check_eq("w_strobe_off", 32'(data_write_n), 32'd3);
        check_eq("w_rsp_valid",  32'(rsp_valid), 32'd1);
        check_eq("w_rsp_err",    32'(rsp_err), 32'd0);
        check_eq("w_rsp_rdata",  rsp_rdata, 32'h0);
        check_eq("w_req_ready",  32'(req_ready), 32'd0);
        consume();
        check_eq("w_done_valid", 32'(rsp_valid), 32'd0);
        check_eq("w_done_ready", 32'(req_ready), 32'd1);
        check_eq("w_data_hold",  data_in, 32'h0000ABCD);

        // 2: 32-bit read, peripheral answers one cycle after strobe
        send_req(1'b0, 2'b10, 6'd4, 32'h0);
        check_eq("r32_strobe",  32'(data_read_n), 32'd2);
        check_eq("r32_address", 32'(address), 32'd4);
        check_eq("r32_wr_idle", 32'(data_write_n), 32'd3);
        tick();
        check_eq("r32_hold",    32'(data_read_n), 32'd2);
        data_ready = 1'b1;
        data_out   = 32'h0000000B;
        tick();
        data_ready = 1'b0;
        check_eq("r32_release", 32'(data_read_n), 32'd3);
        check_eq("r32_valid",   32'(rsp_valid), 32'd1);
        check_eq("r32_rdata",   rsp_rdata, 32'h0000000B);
        check_eq("r32_err",     32'(rsp_err), 32'd0);
        consume();

        // 3: 8-bit read masks upper bytes
        send_req(1'b0, 2'b00, 6'd5, 32'h0);
        check_eq("r8_strobe", 32'(data_read_n), 32'd0);
        data_ready = 1'b1;
        data_out   = 32'hFFFFFF5A;
        tick();
        data_ready = 1'b0;
        check_eq("r8_rdata",  rsp_rdata, 32'h0000005A);
        check_eq("r8_err",    32'(rsp_err), 32'd0);
        consume();

        // 3b: 16-bit read masks upper half
        send_req(1'b0, 2'b01, 6'd6, 32'h0);
        data_ready = 1'b1;
        data_out   = 32'h89ABCDEF;
        tick();
        data_ready = 1'b0;
        check_eq("r16_rdata", rsp_rdata, 32'h0000CDEF);
        consume();

        // 4: read timeout after 16 strobe cycles
        data_out = 32'hDEADBEEF;
        send_req(1'b0, 2'b10, 6'd7, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (data_read_n == 2'b11) break;
            n++;
            tick();
        end
        check_eq("to_strobe_cycles", 32'(n), 32'd16);
        check_eq("to_valid", 32'(rsp_valid), 32'd1);
        check_eq("to_err",   32'(rsp_err), 32'd1);
        check_eq("to_rdata", rsp_rdata, 32'h0);
        consume();
        send_req(1'b0, 2'b10, 6'd8, 32'h0);
        check_eq("to_next_strobe", 32'(data_read_n), 32'd2);
        data_ready = 1'b1;
        data_out   = 32'h12345678;
        tick();
        data_ready = 1'b0;
        check_eq("to_next_rdata", rsp_rdata, 32'h12345678);
        check_eq("to_next_err",   32'(rsp_err), 32'd0);
        consume();

        // 5: illegal size, response held under back-pressure
        send_req(1'b1, 2'b11, 6'd9, 32'h55555555);
        for (int i = 0; i < 5; i++) begin
            check_eq("sz_valid",     32'(rsp_valid), 32'd1);
            check_eq("sz_err",       32'(rsp_err), 32'd2);
            check_eq("sz_rdata",     rsp_rdata, 32'h0);
            check_eq("sz_req_ready", 32'(req_ready), 32'd0);
            check_eq("sz_wr_n",      32'(data_write_n), 32'd3);
            check_eq("sz_rd_n",      32'(data_read_n), 32'd3);
            tick();
        end
        check_eq("sz_data_in", data_in, 32'h12345678 & 32'h0 | 32'h0000ABCD);
        consume();
        check_eq("sz_done_ready", 32'(req_ready), 32'd1);

        // data_ready outside READ is ignored
        data_ready = 1'b1;
        tick();
        tick();
        data_ready = 1'b0;
        check_eq("idle_dr_valid", 32'(rsp_valid), 32'd0);
        check_eq("idle_dr_ready", 32'(req_ready), 32'd1);
        check_eq("idle_dr_rd_n",  32'(data_read_n), 32'd3);

        // 6: reset while read strobe active
        send_req(1'b0, 2'b10, 6'd10, 32'h0);
        check_eq("rr_strobe", 32'(data_read_n), 32'd2);
        #2;
        rst        = 1'b1;
        data_ready = 1'b1;
        data_out   = 32'hCAFEF00D;
        #1;
        check_eq("rr_async_rd_n",  32'(data_read_n), 32'd3);
        check_eq("rr_async_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        data_ready = 1'b0;
        check_eq("rr_post_valid", 32'(rsp_valid), 32'd0);
        check_eq("rr_post_ready", 32'(req_ready), 32'd1);
        check_eq("rr_post_rd_n",  32'(data_read_n), 32'd3);
        check_eq("rr_post_rdata", rsp_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
